therm_peak_meter: RTL and testbench

Downstream consumer of the 3-bit binary-to-7-bit thermometer encoder. It samples a 7-bit thermometer code and checks it for bubbles. It recovers the 3-bit level and keeps a peak-hold value with timed decay. It drives a registered 7-segment bar display: the level thermometer plus a single peak-marker bit. It also keeps a saturating bubble-error counter.

---
 rtl/therm_pkg.sv | 44 ++++
 rtl/therm_to_level.sv | 19 +
 rtl/therm_peak_meter.sv | 163 ++++++++++++++++
 tb/tb_therm_peak_meter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/therm_pkg.sv
// Shared constants, FSM state type and thermometer helpers for the peak meter.
package therm_pkg;

    localparam int N_LEVELS = 7;
    localparam int LW       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_t;

    function automatic logic [N_LEVELS-1:0] level_to_therm(input logic [LW-1:0] lvl);
        logic [N_LEVELS-1:0] t;
        t = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            if (i < int'(lvl)) t[i] = 1'b1;
            else               t[i] = 1'b0;
        end
        return t;
    endfunction

    // Single bar segment at the peak position; level 0 lights nothing.
    function automatic logic [N_LEVELS-1:0] peak_marker(input logic [LW-1:0] pk);
        logic [N_LEVELS-1:0] m;
        m = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            if (int'(pk) == i + 1) m[i] = 1'b1;
            else                   m[i] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic is_legal_therm(input logic [N_LEVELS-1:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < N_LEVELS; i++) begin
            if (t[i] && !t[i-1]) ok = 1'b0;
            else                 ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/therm_to_level.sv
// Combinational decode of a thermometer sample: bubble-tolerant popcount plus legality flag.
module therm_to_level
    import therm_pkg::*;
(
    input  logic [N_LEVELS-1:0] therm_i,
    output logic [LW-1:0]       level_o,
    output logic                legal_o
);

    // Popcount rather than priority decode, so bubbled codes still give a sensible level.
    always_comb begin
        level_o = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            level_o = level_o + {{(LW-1){1'b0}}, therm_i[i]};
        end
        legal_o = is_legal_therm(therm_i);
    end

endmodule

// File: rtl/therm_peak_meter.sv
// Thermometer level meter with peak-hold/decay, registered bar display and bubble-error counter.
module therm_peak_meter
    import therm_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int DECAY_CYCLES = 4,
    parameter int ERR_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [N_LEVELS-1:0] in_therm,
    input  logic                clr_peak,
    output logic [LW-1:0]       level,
    output logic                level_valid,
    output logic [LW-1:0]       peak,
    output logic [N_LEVELS-1:0] bar,
    output logic                bubble_err,
    output logic [ERR_W-1:0]    err_count
);

    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_CYCLES - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

    logic [LW-1:0]       samp_level_s;
    logic                samp_legal_s;
    logic [LW-1:0]       peak_base_s;
    logic                sample_wins_s;

    peak_state_t         state_q, state_d;
    logic [LW-1:0]       peak_q, peak_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DECAY_W-1:0]  decay_cnt_q, decay_cnt_d;

    logic [LW-1:0]       level_q, level_d;
    logic                level_valid_q, level_valid_d;
    logic                bubble_err_q, bubble_err_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [N_LEVELS-1:0] bar_q, bar_d;

    therm_to_level u_decode (
        .therm_i (in_therm),
        .level_o (samp_level_s),
        .legal_o (samp_legal_s)
    );

    // A clear in the same cycle is applied before the sample is judged.
    assign peak_base_s   = clr_peak ? '0 : peak_q;
    assign sample_wins_s = in_valid &&
                           ((samp_level_s > peak_base_s) ||
                            ((samp_level_s == peak_base_s) && (samp_level_s != '0)));
    assign level_d       = in_valid ? samp_level_s : level_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            peak_q      <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            hold_cnt_q  <= hold_cnt_d;
            decay_cnt_q <= decay_cnt_d;
        end
    end

    always_comb begin
        logic [LW-1:0] dec_peak;
        dec_peak    = '0;
        state_d     = state_q;
        peak_d      = peak_q;
        hold_cnt_d  = hold_cnt_q;
        decay_cnt_d = decay_cnt_q;
        if (sample_wins_s) begin
            state_d     = HOLD;
            peak_d      = samp_level_s;
            hold_cnt_d  = '0;
            decay_cnt_d = '0;
        end else if (clr_peak) begin
            state_d     = IDLE;
            peak_d      = '0;
            hold_cnt_d  = '0;
            decay_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d     = DECAY;
                        decay_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                DECAY: begin
                    if (decay_cnt_q == DECAY_LAST) begin
                        dec_peak    = (peak_q == '0) ? '0 : peak_q - LW'(1);
                        peak_d      = dec_peak;
                        decay_cnt_d = '0;
                        // Landing on the current level re-arms the hold instead of sinking below it.
                        if (dec_peak == '0) begin
                            state_d = IDLE;
                        end else if (dec_peak == level_d) begin
                            state_d    = HOLD;
                            hold_cnt_d = '0;
                        end else begin
                            state_d = DECAY;
                        end
                    end else begin
                        decay_cnt_d = decay_cnt_q + DECAY_W'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    peak_d      = '0;
                    hold_cnt_d  = '0;
                    decay_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        level_valid_d = in_valid;
        bubble_err_d  = in_valid & ~samp_legal_s;
        if (bubble_err_d && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
        bar_d = level_to_therm(level_d) | peak_marker(peak_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q       <= '0;
            level_valid_q <= 1'b0;
            bubble_err_q  <= 1'b0;
            err_count_q   <= '0;
            bar_q         <= '0;
        end else begin
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            bubble_err_q  <= bubble_err_d;
            err_count_q   <= err_count_d;
            bar_q         <= bar_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign peak        = peak_q;
    assign bar         = bar_q;
    assign bubble_err  = bubble_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_therm_peak_meter.sv
// Directed scoreboard bench for therm_peak_meter: stimulus queues expectations, a monitor checks them.
module tb_therm_peak_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_therm;
    logic       clr_peak;
    logic [2:0] level;
    logic       level_valid;
    logic [2:0] peak;
    logic [6:0] bar;
    logic       bubble_err;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    therm_peak_meter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_therm    (in_therm),
        .clr_peak    (clr_peak),
        .level       (level),
        .level_valid (level_valid),
        .peak        (peak),
        .bar         (bar),
        .bubble_err  (bubble_err),
        .err_count   (err_count)
    );

    typedef struct {
        int         due;
        string      name;
        bit         full;
        logic [2:0] lvl;
        logic       lv;
        logic [2:0] pk;
        logic [6:0] bar;
        logic       be;
        logic [7:0] ec;
    } exp_t;

    exp_t sbq[$];
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation that falls due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        while (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
            e = sbq.pop_front();
            checks++;
            ok = (level === e.lvl) && (level_valid === e.lv) && (bubble_err === e.be) &&
                 (err_count === e.ec) && (!e.full || ((peak === e.pk) && (bar === e.bar)));
            if (e.due != cyc_cnt) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.name, e.due, cyc_cnt);
            end else if (!ok) begin
                errors++;
                $display("FAIL %s: got level=%0d lv=%0b peak=%0d bar=%b berr=%0b errc=%0d, want level=%0d lv=%0b peak=%0d bar=%b berr=%0b errc=%0d (peak/bar checked=%0b)",
                         e.name, level, level_valid, peak, bar, bubble_err, err_count,
                         e.lvl, e.lv, e.pk, e.bar, e.be, e.ec, e.full);
            end
        end
    end

    task automatic step(input logic v, input logic [6:0] th, input logic clr, input bit chk,
                        input bit full, input string nm, input logic [2:0] el, input logic elv,
                        input logic [2:0] ep, input logic [6:0] eb, input logic ebe,
                        input logic [7:0] eec);
        exp_t e;
        in_valid = v;
        in_therm = th;
        clr_peak = clr;
        if (chk) begin
            e.due  = cyc_cnt + 1;
            e.name = nm;
            e.full = full;
            e.lvl  = el;
            e.lv   = elv;
            e.pk   = ep;
            e.bar  = eb;
            e.be   = ebe;
            e.ec   = eec;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0] p;
    logic [6:0] b;
    bit         c;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_therm = 7'b0;
        clr_peak = 1'b0;
        #1;
        step(1'b1, 7'b0000101, 1'b0, 1, 1, "reset_state", 3'd0, 1'b0, 3'd0, 7'b0000000, 1'b0, 8'd0);
        step(1'b0, 7'b0000000, 1'b0, 1, 1, "reset_hold",  3'd0, 1'b0, 3'd0, 7'b0000000, 1'b0, 8'd0);
        reset = 1'b1;

        step(1'b1, 7'b0011111, 1'b0, 1, 1, "load5",      3'd5, 1'b1, 3'd5, 7'b0011111, 1'b0, 8'd0);
        step(1'b0, 7'b0011111, 1'b0, 1, 1, "idle_hold5", 3'd5, 1'b0, 3'd5, 7'b0011111, 1'b0, 8'd0);
        step(1'b1, 7'b0000101, 1'b0, 1, 1, "bubble",     3'd2, 1'b1, 3'd5, 7'b0010011, 1'b1, 8'd1);
        step(1'b0, 7'b0000101, 1'b0, 1, 1, "bubble_end", 3'd2, 1'b0, 3'd5, 7'b0010011, 1'b0, 8'd1);

        // 300 bubbled samples; the last one also clears the peak so it can be checked exactly.
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 7'b0000101, (i == 300), (i >= 253), (i == 300), "bubble_sat",
                 3'd2, 1'b1, 3'd2, 7'b0000011, 1'b1, (i >= 254) ? 8'd255 : 8'd254);
        end

        // Decay from 7 with level 0: marker walks down every 4 cycles after the hold.
        step(1'b1, 7'b1111111, 1'b0, 1, 1, "decay_load7", 3'd7, 1'b1, 3'd7, 7'b1111111, 1'b0, 8'd255);
        step(1'b1, 7'b0000000, 1'b0, 1, 1, "decay_lvl0",  3'd0, 1'b1, 3'd7, 7'b1000000, 1'b0, 8'd255);
        for (int k = 2; k <= 45; k++) begin
            c = 1'b1;
            case (k)
                19:      begin p = 3'd7; b = 7'b1000000; end
                20, 23:  begin p = 3'd6; b = 7'b0100000; end
                24:      begin p = 3'd5; b = 7'b0010000; end
                28:      begin p = 3'd4; b = 7'b0001000; end
                32:      begin p = 3'd3; b = 7'b0000100; end
                36:      begin p = 3'd2; b = 7'b0000010; end
                40, 43:  begin p = 3'd1; b = 7'b0000001; end
                44, 45:  begin p = 3'd0; b = 7'b0000000; end
                default: begin c = 1'b0; p = 3'd0; b = 7'b0000000; end
            endcase
            step(1'b0, 7'b0000000, 1'b0, c, 1, "decay_walk", 3'd0, 1'b0, p, b, 1'b0, 8'd255);
        end

        // Floor: decay stops at the held level 3 and re-arms the hold.
        step(1'b1, 7'b1111111, 1'b0, 1, 1, "floor_load7", 3'd7, 1'b1, 3'd7, 7'b1111111, 1'b0, 8'd255);
        step(1'b1, 7'b0000111, 1'b0, 1, 1, "floor_lvl3",  3'd3, 1'b1, 3'd7, 7'b1000111, 1'b0, 8'd255);
        for (int k = 2; k <= 51; k++) begin
            c = 1'b1;
            case (k)
                20:         begin p = 3'd6; b = 7'b0100111; end
                24:         begin p = 3'd5; b = 7'b0010111; end
                28, 31:     begin p = 3'd4; b = 7'b0001111; end
                32, 36, 51: begin p = 3'd3; b = 7'b0000111; end
                default:    begin c = 1'b0; p = 3'd0; b = 7'b0000000; end
            endcase
            step(1'b0, 7'b0000000, 1'b0, c, 1, "floor_walk", 3'd3, 1'b0, p, b, 1'b0, 8'd255);
        end

        // A decrement is due on this edge; the higher sample pre-empts it.
        step(1'b1, 7'b0111111, 1'b0, 1, 1, "preempt_load6", 3'd6, 1'b1, 3'd6, 7'b0111111, 1'b0, 8'd255);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 7'b0000000, 1'b0, (k >= 15), 1, "hold6", 3'd6, 1'b0, 3'd6, 7'b0111111, 1'b0, 8'd255);
        end
        step(1'b1, 7'b0000011, 1'b1, 1, 1, "collision", 3'd2, 1'b1, 3'd2, 7'b0000011, 1'b0, 8'd255);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 7'b0000000, 1'b0, (k == 4 || k >= 19), 1, "collision_hold",
                 3'd2, 1'b0, (k == 20) ? 3'd1 : 3'd2, 7'b0000011, 1'b0, 8'd255);
        end

        // Reset in the middle of a hold, then behave as from power-up.
        step(1'b1, 7'b0011111, 1'b0, 1, 1, "rst_load5", 3'd5, 1'b1, 3'd5, 7'b0011111, 1'b0, 8'd255);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 7'b0000000, 1'b0, (k == 3), 1, "rst_hold5", 3'd5, 1'b0, 3'd5, 7'b0011111, 1'b0, 8'd255);
        end
        reset = 1'b0;
        step(1'b1, 7'b0000101, 1'b0, 1, 1, "reset_mid_hold", 3'd0, 1'b0, 3'd0, 7'b0000000, 1'b0, 8'd0);
        reset = 1'b1;
        step(1'b1, 7'b0000111, 1'b0, 1, 1, "post_rst_load3", 3'd3, 1'b1, 3'd3, 7'b0000111, 1'b0, 8'd0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 7'b0000000, 1'b0, (k >= 19), 1, "post_rst_hold",
                 3'd3, 1'b0, (k == 20) ? 3'd2 : 3'd3, 7'b0000111, 1'b0, 8'd0);
        end
        step(1'b0, 7'b0000000, 1'b1, 1, 1, "clr_only",   3'd3, 1'b0, 3'd0, 7'b0000111, 1'b0, 8'd0);
        step(1'b1, 7'b0000001, 1'b0, 1, 1, "legal_low",  3'd1, 1'b1, 3'd1, 7'b0000001, 1'b0, 8'd0);
        step(1'b1, 7'b0000000, 1'b0, 1, 1, "zero_below", 3'd0, 1'b1, 3'd1, 7'b0000001, 1'b0, 8'd0);
        step(1'b1, 7'b1000000, 1'b0, 1, 1, "bubble_top", 3'd1, 1'b1, 3'd1, 7'b0000001, 1'b1, 8'd1);
        step(1'b0, 7'b0000000, 1'b0, 1, 1, "final_idle", 3'd1, 1'b0, 3'd1, 7'b0000001, 1'b0, 8'd1);

        step(1'b0, 7'b0000000, 1'b0, 0, 0, "drain", 3'd0, 1'b0, 3'd0, 7'b0000000, 1'b0, 8'd0);
        step(1'b0, 7'b0000000, 1'b0, 0, 0, "drain", 3'd0, 1'b0, 3'd0, 7'b0000000, 1'b0, 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
